// File: rtl/fpu_conv_sched.sv
// fpu_conv_sched: round-robin scheduler sharing one fixed-latency conversion unit
// (itof / ftoi) among NREQ requesters. Each accepted request is issued to the unit
// on the following cycle. Its requester ID travels down a LAT+1 stage pipe, so the
// result comes back tagged with the ID of the requester that sent it.
//
// Optional feature: define FPU_CONV_SCHED_PERF_EN to add the perf_issue and
// perf_conflict counters and their output ports.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req_valid      per-requester request valid            [NREQ]
//   req_op         per-requester op, 0 = itof, 1 = ftoi   [NREQ]
//   req_data       per-requester operand, 32 bits each    [32*NREQ]
//   req_ready      one-hot combinational grant            [NREQ]
//   u_x, u_op      registered operand and op to the conversion unit
//   u_y            conversion-unit result
//   resp_valid     registered result-valid, from the pipe tail
//   resp_id        registered requester ID of the result  [IDW]
//   resp_data      result, passed straight through from u_y
//   drain          stop granting new requests
//   idle           no request in flight and no issue this cycle
//   perf_issue     (optional) handshake count
//   perf_conflict  (optional) count of contended cycles in RUN
module fpu_conv_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          u_x,
  output logic                 u_op,
  input  logic [31:0]          u_y,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  input  logic                 drain,
  output logic                 idle
`ifdef FPU_CONV_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issue,
  output logic [31:0]          perf_conflict
`endif
);

  // Index widths: requester select, operand bit-select, pipe depth.
  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DW   = 32 * NREQ;
  localparam int unsigned DSW  = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned PW   = LAT + 1;
  localparam int unsigned PIW  = PW * IDW;

  localparam logic [PW-1:0] TAIL_MASK = PW'(1) << LAT;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [PW-1:0]   pv;
  logic [PIW-1:0]  pid;

  logic            hs;
  logic [SELW-1:0] gnt;
  int unsigned     idx;
  logic            pipe_drains;

  // Round-robin search from ptr, wrapping modulo NREQ. Drain masks grants in the
  // same cycle it rises.
  always_comb begin
    hs        = 1'b0;
    gnt       = '0;
    idx       = 0;
    req_ready = '0;
    if (state == ST_RUN && !drain) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!hs && req_valid[SELW'(idx)]) begin
          hs  = 1'b1;
          gnt = SELW'(idx);
        end
      end
    end
    req_ready[gnt] = hs;
  end

  // True when the pipe will hold nothing after this edge. Only the tail may be
  // occupied, and that entry leaves on this edge. No issue is possible while draining.
  assign pipe_drains = ((pv & ~TAIL_MASK) == '0) && !hs;

  // State, pointer, issue registers and the ID pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      ptr   <= '0;
      u_x   <= '0;
      u_op  <= 1'b0;
      pv    <= '0;
      pid   <= '0;
    end else begin
      pv  <= PW'({pv, hs});
      pid <= PIW'({pid, IDW'(gnt)});

      if (hs) begin
        u_x  <= req_data[DSW'({gnt, 5'b0}) +: 32];
        u_op <= req_op[gnt];
        ptr  <= (32'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
      end

      case (state)
        ST_RUN: begin
          if (drain) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pipe_drains)  state <= ST_IDLE;
          else if (!drain)  state <= ST_RUN;
        end
        ST_IDLE: begin
          if (!drain) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign resp_valid = pv[LAT];
  assign resp_id    = pid[LAT*IDW +: IDW];
  assign resp_data  = u_y;

  assign idle = (state == ST_IDLE) || (state == ST_RUN && pv == '0 && !hs);

`ifdef FPU_CONV_SCHED_PERF_EN
  // Free-running counters. Only reset clears them; drain does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue    <= '0;
      perf_conflict <= '0;
    end else begin
      if (hs) perf_issue <= perf_issue + 32'd1;
      if (state == ST_RUN && $countones(req_valid) >= 2)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fpu_conv_sched.md
Name: fpu_conv_sched

Overview:
- Shares one fixed-latency FPU conversion unit (itof / ftoi datapath) among NREQ requesters.
- Round-robin grant, at most one issue per cycle. Tracks in-flight requester IDs through a shift pipe and returns each result tagged with its requester ID.
- Drain control lets the core quiesce the unit, e.g. before a mode change or halt.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, conversion-unit latency in cycles from u_x/u_op to valid u_y (0 = combinational unit).
- IDW, 2, requester-ID width, must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_op  in  NREQ  per-requester op: 0 = itof, 1 = ftoi.
- req_data  in  32*NREQ  per-requester operand; requester i occupies bits [32i+31:32i].
- req_ready  out  NREQ  one-hot grant; the handshake completes on req_valid[i] & req_ready[i].
- u_x  out  32  operand to the conversion unit (registered).
- u_op  out  1  op to the conversion unit (registered).
- u_y  in  32  conversion-unit result.
- resp_valid  out  1  result valid this cycle.
- resp_id  out  IDW  requester ID of the result.
- resp_data  out  32  result; equals u_y when resp_valid is 1.
- drain  in  1  stop granting new requests.
- idle  out  1  no request in flight and state is not RUN-with-issue.

Behaviour:
- Reset:
  - All outputs 0: req_ready=0, u_x=0, u_op=0, resp_valid=0, resp_id=0.
  - RR pointer = 0, pipe cleared, state = RUN.
  - Asserting rst mid-operation drops every in-flight op; no response is produced for them.
- Grant:
  - Combinational from req_valid and the RR pointer.
  - Search order is ptr, ptr+1, ..., wrapping modulo NREQ; the first valid requester gets req_ready.
  - req_ready is all-zero when no request is valid or state != RUN.
- Pointer: on a handshake by requester g, ptr <= (g+1) mod NREQ; otherwise it holds.
- Issue: on the handshake cycle t, the next edge loads u_x <= req_data[g], u_op <= req_op[g], and pipe stage 0 <= {valid=1, id=g}. With no handshake, u_x/u_op hold and stage 0 valid <= 0.
- Pipe:
  - LAT+1 stages of {valid, id}, shifted every cycle with no backpressure.
  - The tail drives resp_valid/resp_id; resp_data = u_y combinationally.
  - A request accepted at cycle t responds at cycle t+1+LAT.
  - Responses come out in issue order, one per cycle max, back-to-back allowed.
  - The consumer must accept every response.
- Throughput: 1 op/cycle sustained; with all NREQ valid, grants rotate 0,1,2,3,0,...
- FSM:
  - RUN: grants enabled. drain=1 -> DRAIN (takes effect the same cycle: req_ready forced 0 while drain=1).
  - DRAIN: no grants. Pipe empty -> IDLE. drain=0 with pipe non-empty -> RUN.
  - IDLE: no grants, idle=1. drain=0 -> RUN.
- idle=1 in IDLE, and in RUN when pipe empty and no handshake this cycle.
- Simultaneous events:
  - drain rising in the same cycle as a request: the request is not granted.
  - Handshake and response in the same cycle are independent.
- Width rule: IDs >= NREQ are never generated; requester bits above NREQ do not exist.

Optional Feature:
- Macro FPU_CONV_SCHED_PERF_EN.
- With it defined, adds two outputs:
  - perf_issue (32): count of handshakes.
  - perf_conflict (32): count of cycles with at least two req_valid bits set and state RUN.
  - Both reset to 0, wrap modulo 2^32, and are not cleared by drain.
- Without it, neither port nor its counters exist, and behaviour is otherwise identical.

Test Plan:
- Single op: req_valid=0001, req_op=0, data=32'h0000_0003, unit models itof with LAT=2. Handshake at cycle 5 -> resp_valid=1 at cycle 8, resp_id=0, resp_data=32'h4040_0000.
- Round-robin: req_valid=1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses arrive with the same ID order, back-to-back.
- Fairness skip: ptr=1, req_valid=1001 -> grant 3, then ptr=0 -> grant 0.
- Drain: 3 ops in flight, raise drain -> req_ready=0 immediately, 3 responses delivered, idle=1 exactly one cycle after the last resp_valid, state IDLE; drop drain -> next grant the following cycle.
- Reset mid-flight: assert rst with 2 ops in pipe -> all outputs 0 asynchronously, no resp_valid after release, ptr=0.
- Perf (macro defined): 10 cycles of req_valid=0011 -> perf_issue=10, perf_conflict=10.
